// File: rtl/rv32_pkg.sv
// Shared rv32 core types: writeback source select, load funct3 codes
// and writeback-stage FSM states.
package rv32_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_WAIT_LOAD = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment and sign/zero extension.
// Purely combinational; also used by the debug memory-read path.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_shift;

    assign w_shift = i_data >> {i_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    // Halves ignore addr[0]; misalignment is caught upstream.
    assign w_half  = i_off[1] ? i_data[31:16] : i_data[15:0];

    always_comb begin
        o_data = i_data;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_data = {16'd0, w_half};
            F3_LW:   o_data = i_data;
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final rv32 pipeline stage: one register write per retired instruction,
// load response alignment, bypass copy and 64-bit instret.
module writeback_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_rd,
    input  logic [1:0]  m_wb_sel,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_pc,
    input  logic [2:0]  m_funct3,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        w_en,
    output logic [4:0]  rd,
    output logic [31:0] w_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        retire,
    output logic [63:0] instret
);

    wb_state_e   r_state;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic [31:0] r_result;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic [63:0] r_instret;

    wb_sel_e     w_sel;
    logic        w_accept;
    logic [31:0] w_result;
    logic [31:0] w_load_data;

    assign w_sel    = wb_sel_e'(m_wb_sel);
    assign m_ready  = (r_state != S_WAIT_LOAD);
    assign w_accept = m_valid && m_ready;

    always_comb begin
        w_result = 32'd0;
        case (w_sel)
            WB_ALU:  w_result = m_alu_result;
            WB_PC4:  w_result = m_pc + 32'd4;
            default: w_result = 32'd0;
        endcase
    end

    load_align u_align (
        .i_data   (rsp_data),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd      <= 5'd0;
            r_wen     <= 1'b0;
            r_result  <= 32'd0;
            r_off     <= 2'd0;
            r_f3      <= 3'd0;
            r_instret <= 64'd0;
        end else begin
            if (r_state == S_WRITE)
                r_instret <= r_instret + 64'd1;
            r_wen <= 1'b0;
            case (r_state)
                S_WAIT_LOAD: begin
                    if (rsp_valid) begin
                        r_state  <= S_WRITE;
                        r_result <= w_load_data;
                        r_wen    <= (r_rd != 5'd0);
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_rd  <= m_rd;
                        r_off <= m_alu_result[1:0];
                        r_f3  <= m_funct3;
                        if (w_sel == WB_LOAD) begin
                            r_state <= S_WAIT_LOAD;
                        end else begin
                            r_state  <= S_WRITE;
                            r_result <= w_result;
                            r_wen    <= (m_rd != 5'd0) && (w_sel != WB_NONE);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign w_en      = r_wen;
    assign rd        = r_rd;
    assign w_data    = r_result;
    assign retire    = (r_state == S_WRITE);
    assign instret   = r_instret;
    assign fwd_valid = r_wen;
    assign fwd_rd    = r_rd;
    assign fwd_data  = r_result;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised self-checking bench for writeback_stage against a
// transaction-level model of retired writes and register contents.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_ready;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_wb_sel = '0;
    logic [31:0] m_alu_result = '0;
    logic [31:0] m_pc = '0;
    logic [2:0]  m_funct3 = '0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        w_en;
    logic [4:0]  rd;
    logic [31:0] w_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        retire;
    logic [63:0] instret;

    writeback_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_rd         (m_rd),
        .m_wb_sel     (m_wb_sel),
        .m_alu_result (m_alu_result),
        .m_pc         (m_pc),
        .m_funct3     (m_funct3),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .w_en         (w_en),
        .rd           (rd),
        .w_data       (w_data),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .retire       (retire),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model
    logic        mdl_busy = 1'b0;
    logic [4:0]  pend_rd;
    logic [1:0]  pend_off;
    logic [2:0]  pend_f3;
    logic        exp_retire = 1'b0;
    logic        exp_wen = 1'b0;
    logic [4:0]  exp_rd = '0;
    logic [31:0] exp_data = '0;
    logic [63:0] mdl_cnt = '0;
    logic [31:0] mdl_regs [32];
    logic [31:0] dut_regs [32];

    function automatic logic [31:0] ref_load(input logic [31:0] d,
                                             input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic mdl_reset();
        mdl_busy   = 1'b0;
        exp_retire = 1'b0;
        exp_wen    = 1'b0;
        exp_rd     = '0;
        exp_data   = '0;
        mdl_cnt    = '0;
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic tick(input logic v, input logic [1:0] sel,
                        input logic [4:0] t_rd, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3,
                        input logic rv, input logic [31:0] rdat);
        m_valid      = v;
        m_wb_sel     = sel;
        m_rd         = t_rd;
        m_alu_result = alu;
        m_pc         = pc;
        m_funct3     = f3;
        rsp_valid    = rv;
        rsp_data     = rdat;
        if (w_en) dut_regs[rd] = w_data;
        @(posedge clk);
        mdl_cnt = mdl_cnt + (exp_retire ? 64'd1 : 64'd0);
        exp_retire = 1'b0;
        exp_wen = 1'b0;
        if (mdl_busy) begin
            if (rv) begin
                mdl_busy   = 1'b0;
                exp_retire = 1'b1;
                exp_rd     = pend_rd;
                exp_data   = ref_load(rdat, pend_off, pend_f3);
                exp_wen    = (pend_rd != 0);
            end
        end else if (v) begin
            if (sel == 2'd2) begin
                mdl_busy = 1'b1;
                pend_rd  = t_rd;
                pend_off = alu[1:0];
                pend_f3  = f3;
            end else begin
                exp_retire = 1'b1;
                exp_rd     = t_rd;
                exp_data   = (sel == 2'd1) ? alu : (sel == 2'd3) ? pc + 32'd4 : 32'd0;
                exp_wen    = (t_rd != 0) && (sel != 2'd0);
            end
        end
        if (exp_wen) mdl_regs[exp_rd] = exp_data;
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_m_ready got=%b exp=1", m_ready);
        end
        checks++;
        if ({w_en, rd, w_data, retire, instret} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got w_en=%b rd=%0d data=%h ret=%b instret=%0d exp all 0",
                     w_en, rd, w_data, retire, instret);
        end
        checks++;
        if ({fwd_valid, fwd_rd, fwd_data} !== '0) begin
            failures++;
            $display("FAIL reset_fwd got %b/%0d/%h exp 0", fwd_valid, fwd_rd, fwd_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [63:0] base;
        idle();
        base = instret;
        tick(1'b1, 2'd1, 5'd5, 32'h1234_5678, 32'h100, 3'd0, 1'b0, 32'd0);
        checks++;
        if ({w_en, rd, w_data, retire} !== {1'b1, 5'd5, 32'h1234_5678, 1'b1}) begin
            failures++;
            $display("FAIL alu_write got w_en=%b rd=%0d data=%h ret=%b exp 1/5/12345678/1",
                     w_en, rd, w_data, retire);
        end
        idle();
        checks++;
        if (instret !== base + 64'd1 || retire !== 1'b0) begin
            failures++;
            $display("FAIL alu_instret got=%0d ret=%b exp=%0d ret=0", instret, retire, base + 64'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] base;
        logic [4:0]  rds [3];
        rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd0;
        base = instret;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 2'd1, rds[i], 32'hA000_0000 + i, 32'd0, 3'd0, 1'b0, 32'd0);
            checks++;
            if ({w_en, rd, w_data, retire} !== {(i != 2), rds[i], 32'hA000_0000 + i, 1'b1}) begin
                failures++;
                $display("FAIL b2b_%0d got w_en=%b rd=%0d data=%h ret=%b", i, w_en, rd, w_data, retire);
            end
        end
        idle();
        checks++;
        if (instret !== base + 64'd3) begin
            failures++;
            $display("FAIL b2b_instret got=%0d exp=%0d", instret, base + 64'd3);
        end
    endtask

    task automatic test_pc4();
        tick(1'b1, 2'd3, 5'd1, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 3'd0, 1'b0, 32'd0);
        checks++;
        if ({w_en, rd, w_data} !== {1'b1, 5'd1, 32'h0000_0000}) begin
            failures++;
            $display("FAIL pc4_wrap got w_en=%b rd=%0d data=%h exp 1/1/00000000", w_en, rd, w_data);
        end
        idle();
    endtask

    task automatic load_case(input string nm, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [31:0] expd);
        tick(1'b1, 2'd2, 5'd7, addr, 32'd0, f3, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_ready !== 1'b0 || w_en !== 1'b0 || retire !== 1'b0) begin
                failures++;
                $display("FAIL %s_wait%0d got ready=%b w_en=%b ret=%b exp 0/0/0", nm, i, m_ready, w_en, retire);
            end
            tick(1'b1, 2'd1, 5'd9, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
        end
        checks++;
        if (m_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait2 got ready=%b exp 0", nm, m_ready);
        end
        tick(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h80FF_0102);
        checks++;
        if ({m_ready, w_en, rd, w_data, retire} !== {1'b1, 1'b1, 5'd7, expd, 1'b1}) begin
            failures++;
            $display("FAIL %s_data got ready=%b w_en=%b rd=%0d data=%h exp data=%h",
                     nm, m_ready, w_en, rd, w_data, expd);
        end
        idle();
    endtask

    task automatic test_loads();
        load_case("lb", 32'h0000_1003, 3'b000, 32'hFFFF_FF80);
        load_case("lhu", 32'h0000_1002, 3'b101, 32'h0000_80FF);
        load_case("lh", 32'h0000_1002, 3'b001, 32'hFFFF_80FF);
    endtask

    task automatic test_stray_rsp();
        logic [63:0] base;
        base = instret;
        tick(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h5555_5555);
        checks++;
        if ({w_en, retire, m_ready} !== 3'b001 || instret !== base) begin
            failures++;
            $display("FAIL stray_rsp got w_en=%b ret=%b ready=%b instret=%0d exp 0/0/1/%0d",
                     w_en, retire, m_ready, instret, base);
        end
    endtask

    task automatic test_reset_mid_load();
        tick(1'b1, 2'd2, 5'd3, 32'h40, 32'd0, 3'b010, 1'b0, 32'd0);
        tick(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        checks++;
        if ({m_ready, w_en, retire} !== 3'b100 || instret !== 64'd0) begin
            failures++;
            $display("FAIL midload_reset got ready=%b w_en=%b ret=%b instret=%0d exp 1/0/0/0",
                     m_ready, w_en, retire, instret);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1, 32'hCAFE_F00D);
        checks++;
        if ({m_ready, w_en, retire} !== 3'b100 || instret !== 64'd0) begin
            failures++;
            $display("FAIL midload_late_rsp got ready=%b w_en=%b ret=%b instret=%0d exp 1/0/0/0",
                     m_ready, w_en, retire, instret);
        end
    endtask

    task automatic test_random_stream();
        int n = 0;
        int cyc = 0;
        logic v, rv;
        while (n < 1000 && cyc < 20000) begin
            v  = ($urandom_range(0, 3) != 0);
            rv = mdl_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            if (v && !mdl_busy) n++;
            tick(v, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
                 $urandom, 3'($urandom_range(0, 7)), rv, $urandom);
            cyc++;
            checks++;
            if ({fwd_valid, fwd_rd, fwd_data} !== {w_en, rd, w_data}) begin
                failures++;
                $display("FAIL rnd_fwd cyc=%0d got %b/%0d/%h exp %b/%0d/%h",
                         cyc, fwd_valid, fwd_rd, fwd_data, w_en, rd, w_data);
            end
            checks++;
            if (w_en !== exp_wen || retire !== exp_retire || m_ready !== !mdl_busy ||
                instret !== mdl_cnt) begin
                failures++;
                $display("FAIL rnd_ctrl cyc=%0d got w_en=%b ret=%b rdy=%b cnt=%0d exp %b/%b/%b/%0d",
                         cyc, w_en, retire, m_ready, instret, exp_wen, exp_retire, !mdl_busy, mdl_cnt);
            end
            if (exp_retire) begin
                checks++;
                if (rd !== exp_rd || w_data !== exp_data) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got rd=%0d data=%h exp rd=%0d data=%h",
                             cyc, rd, w_data, exp_rd, exp_data);
                end
            end
        end
        checks++;
        if (n < 1000) begin
            failures++;
            $display("FAIL rnd_budget got=%0d instrs exp=1000", n);
        end
        while (mdl_busy && cyc < 20100) begin
            tick(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1, $urandom);
            cyc++;
        end
        idle();
        idle();
        for (int r = 1; r < 32; r++) begin
            checks++;
            if (dut_regs[r] !== mdl_regs[r]) begin
                failures++;
                $display("FAIL regfile_x%0d got=%h exp=%h", r, dut_regs[r], mdl_regs[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            mdl_regs[r] = '0;
            dut_regs[r] = '0;
        end
        #2;
        test_reset();
        test_alu();
        test_back_to_back();
        test_pc4();
        test_loads();
        test_stray_rsp();
        test_reset_mid_load();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
